// File: rtl/sensor_sim_pkg.sv
// Shared definitions for the multi-channel sensor stream simulator:
// default widths, the stream FSM state encoding and the channel-tag width helper.
package sensor_sim_pkg;

  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_DATA_W  = 110;
  localparam int DEF_TIMER_W = 20;
  localparam int DEF_IDX_W   = 6;
  localparam int DEF_OVR_W   = 16;

  // Stream FSM: arbitrate, look the packet up, then offer it downstream.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } streamState_t;

  // Width of a channel tag; never narrower than one bit so tiny configurations
  // still get a legal vector.
  function automatic int chWidth(input int numCh);
    return (numCh < 2) ? 1 : $clog2(numCh);
  endfunction

endpackage

// File: rtl/sensor_ch_timer.sv
// One simulated sensor channel: a free-running period timer that raises a
// sticky pending flag each time it reaches its programmed cap.
module sensor_ch_timer
  import sensor_sim_pkg::*;
#(
  parameter int TIMER_W = DEF_TIMER_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               i_run,
  input  logic [TIMER_W-1:0] i_cap,
  input  logic               i_clear,
  output logic               o_fire,
  output logic               o_pending
);

  logic [TIMER_W-1:0] r_count;
  logic               r_pending;
  logic               w_capOn;

  // A zero cap switches the channel off; a fire only happens while running
  // and only on an exact match, so a cap lowered below the count waits for wrap.
  assign w_capOn   = (i_cap != '0);
  assign o_fire    = i_run && w_capOn && (r_count == i_cap);
  assign o_pending = r_pending;

  // Period counter: parked at zero when off, reloads on fire, holds when not running.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (!w_capOn) begin
      r_count <= '0;
    end else if (o_fire) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  // Pending flag: a new fire beats a same-cycle clear from the fetch stage.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
    end else if (o_fire) begin
      r_pending <= 1'b1;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_stream_sim.sv
// Multi-channel sensor simulator top: per-channel timers, round-robin arbiter,
// data-store fetch, valid/ready packet output and overrun accounting.
module sensor_stream_sim
  import sensor_sim_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMER_W = DEF_TIMER_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int OVR_W   = DEF_OVR_W,
  localparam int CH_W   = chWidth(NUM_CH)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      run,
  input  logic [NUM_CH*TIMER_W-1:0] timer_cap,
  output logic [CH_W-1:0]           fetch_ch,
  output logic [IDX_W-1:0]          fetch_idx,
  input  logic [DATA_W-1:0]         fetch_data,
  output logic [DATA_W-1:0]         out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         overrun_flags,
  output logic [OVR_W-1:0]          overrun_count
);

  localparam int OVR_SUM_W = OVR_W + 1;

  streamState_t r_state;
  streamState_t w_nextState;

  logic [NUM_CH-1:0]    w_fire;
  logic [NUM_CH-1:0]    w_pending;
  logic [NUM_CH-1:0]    w_clear;
  logic [NUM_CH-1:0]    w_ovr;
  logic                 w_anyPending;

  logic [CH_W-1:0]      r_grant;
  logic [CH_W-1:0]      r_lastGrant;
  logic [CH_W-1:0]      w_rrGrant;
  logic [CH_W-1:0]      w_cand;
  logic                 w_rrFound;
  logic [CH_W-1:0]      w_fetchSel;

  logic [IDX_W-1:0]     r_idx [NUM_CH];

  logic [DATA_W-1:0]    r_outData;
  logic [CH_W-1:0]      r_outCh;
  logic [IDX_W-1:0]     r_outIdx;

  logic                 w_loadGrant;
  logic                 w_doFetch;
  logic                 w_sendValid;
  logic                 w_accept;

  logic [NUM_CH-1:0]    r_ovrFlags;
  logic [OVR_W-1:0]     r_ovrCount;
  logic [OVR_SUM_W-1:0] w_ovrNum;
  logic [OVR_SUM_W-1:0] w_ovrSum;
  logic [OVR_W-1:0]     w_ovrNext;

  // ------------------------------------------------------------------
  // Channel timers plus the per-channel clear and overrun terms
  // ------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sensor_ch_timer #(
      .TIMER_W (TIMER_W)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .i_run     (run),
      .i_cap     (timer_cap[g*TIMER_W +: TIMER_W]),
      .i_clear   (w_clear[g]),
      .o_fire    (w_fire[g]),
      .o_pending (w_pending[g])
    );

    // A fetch retires this channel's pending sample.
    assign w_clear[g] = w_doFetch && (r_grant == CH_W'(g));
    // A fire onto a sample that is still waiting drops the new sample.
    assign w_ovr[g]   = w_fire[g] && w_pending[g] && !w_clear[g];
  end

  assign w_anyPending = |w_pending;

  // Round-robin search: first pending channel after the last one served, wrapping.
  always_comb begin
    w_rrGrant = r_lastGrant;
    w_rrFound = 1'b0;
    w_cand    = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      w_cand = CH_W'((int'(r_lastGrant) + off) % NUM_CH);
      if (!w_rrFound && w_pending[w_cand]) begin
        w_rrFound = 1'b1;
        w_rrGrant = w_cand;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stream FSM
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: one arbitration cycle, one fetch cycle, then hold until accepted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyPending) w_nextState = FETCH;
      FETCH:   w_nextState = SEND;
      SEND:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State-decoded controls for the datapath below.
  always_comb begin
    w_loadGrant = 1'b0;
    w_doFetch   = 1'b0;
    w_sendValid = 1'b0;
    case (r_state)
      IDLE:    w_loadGrant = w_anyPending;
      FETCH:   w_doFetch   = 1'b1;
      SEND:    w_sendValid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = w_sendValid && out_ready;

  // ------------------------------------------------------------------
  // Arbiter and index datapath
  // ------------------------------------------------------------------

  // Registered grant so the data-store select is stable through FETCH.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_grant <= CH_W'(NUM_CH - 1);
    end else if (w_loadGrant) begin
      r_grant <= w_rrGrant;
    end
  end

  // Rotation pointer only moves once a channel has actually been fetched.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lastGrant <= CH_W'(NUM_CH - 1);
    end else if (w_doFetch) begin
      r_lastGrant <= r_grant;
    end
  end

  // Per-channel sample index; advances only for samples that were fetched.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_idx[k] <= '0;
      end
    end else if (w_doFetch) begin
      r_idx[r_grant] <= r_idx[r_grant] + IDX_W'(1);
    end
  end

  // Outside FETCH the select rests on the last served channel.
  assign w_fetchSel = (r_state == FETCH) ? r_grant : r_lastGrant;
  assign fetch_ch   = w_fetchSel;
  assign fetch_idx  = r_idx[w_fetchSel];

  // ------------------------------------------------------------------
  // Output packet registers
  // ------------------------------------------------------------------

  // Capture the looked-up packet in FETCH; blank the payload once accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_outData <= '0;
      r_outCh   <= '0;
      r_outIdx  <= '0;
    end else if (w_doFetch) begin
      r_outData <= fetch_data;
      r_outCh   <= r_grant;
      r_outIdx  <= r_idx[r_grant];
    end else if (w_accept) begin
      r_outData <= '0;
    end
  end

  assign out_data  = r_outData;
  assign out_ch    = r_outCh;
  assign out_idx   = r_outIdx;
  assign out_valid = w_sendValid;
  assign pending   = w_pending;

  // ------------------------------------------------------------------
  // Overrun accounting
  // ------------------------------------------------------------------

  // Add every channel that overran this cycle and clamp at all-ones.
  always_comb begin
    w_ovrNum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_ovrNum = w_ovrNum + OVR_SUM_W'(w_ovr[k]);
    end
    w_ovrSum  = {1'b0, r_ovrCount} + w_ovrNum;
    w_ovrNext = w_ovrSum[OVR_W] ? '1 : w_ovrSum[OVR_W-1:0];
  end

  // Sticky flags and the saturating total; only reset clears them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovrFlags <= '0;
      r_ovrCount <= '0;
    end else begin
      r_ovrFlags <= r_ovrFlags | w_ovr;
      r_ovrCount <= w_ovrNext;
    end
  end

  assign overrun_flags = r_ovrFlags;
  assign overrun_count = r_ovrCount;

endmodule

// File: tb/tb_sensor_stream_sim.sv
// Testbench for sensor_stream_sim: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from a cycle-level behavioural channel model.
`timescale 1ns/1ps
module tb_sensor_stream_sim;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 110;
  localparam int TIMER_W = 20;
  localparam int IDX_W   = 6;
  localparam int OVR_W   = 16;
  localparam int CH_W    = 3;
  localparam int IDX_MOD = 1 << IDX_W;
  localparam int TMR_MOD = 1 << TIMER_W;
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic                      clock = 1'b0;
  logic                      resetn = 1'b0;
  logic                      run = 1'b0;
  logic [NUM_CH*TIMER_W-1:0] timerCap = '0;
  logic [CH_W-1:0]           fetchCh;
  logic [IDX_W-1:0]          fetchIdx;
  logic [DATA_W-1:0]         fetchData;
  logic [DATA_W-1:0]         outData;
  logic [CH_W-1:0]           outCh;
  logic [IDX_W-1:0]          outIdx;
  logic                      outValid;
  logic                      outReady = 1'b1;
  logic [NUM_CH-1:0]         pendingVec;
  logic [NUM_CH-1:0]         overrunFlags;
  logic [OVR_W-1:0]          overrunCount;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int                ch;
    int                idx;
    logic [DATA_W-1:0] data;
  } packet_t;

  packet_t expQ[$];
  int      chLog[$];
  int      idxLog[$];
  int      cycLog[$];
  int      acceptCount = 0;
  int      cycNum = 0;

  // Behavioural model state: per-channel counters and flags, plus which
  // channel (if any) the single packet slot is working on.
  int mTimer   [NUM_CH];
  bit mPend    [NUM_CH];
  int mIdx     [NUM_CH];
  bit mOvrFlag [NUM_CH];
  int mOvrCount;
  int mLast;
  int mSel;
  int mStage;   // 0 = looking for work, 1 = channel chosen, 2 = packet on offer

  sensor_stream_sim #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .TIMER_W (TIMER_W),
    .IDX_W   (IDX_W),
    .OVR_W   (OVR_W)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .run           (run),
    .timer_cap     (timerCap),
    .fetch_ch      (fetchCh),
    .fetch_idx     (fetchIdx),
    .fetch_data    (fetchData),
    .out_data      (outData),
    .out_ch        (outCh),
    .out_idx       (outIdx),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .pending       (pendingVec),
    .overrun_flags (overrunFlags),
    .overrun_count (overrunCount)
  );

  always #5 clock = ~clock;

  // Synthetic data store: a distinct word for every (channel, index) pair.
  function automatic logic [DATA_W-1:0] storeWord(input int ch, input int idx);
    logic [127:0] acc;
    logic [31:0]  h;
    h   = (32'(ch + 1) * 32'h9E3779B1) ^ (32'(idx) * 32'h85EBCA6B);
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      acc = {acc[95:0], h ^ (32'(j) * 32'h01234567)};
    end
    return acc[DATA_W-1:0];
  endfunction

  assign fetchData = storeWord(int'(fetchCh), int'(fetchIdx));

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] modelPendVec();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = mPend[k];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] modelFlagVec();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = mOvrFlag[k];
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NUM_CH; k++) begin
      mTimer[k]   = 0;
      mPend[k]    = 1'b0;
      mIdx[k]     = 0;
      mOvrFlag[k] = 1'b0;
    end
    mOvrCount = 0;
    mLast     = NUM_CH - 1;
    mSel      = 0;
    mStage    = 0;
    expQ.delete();
  endtask

  // One clock of the reference: service slot first (using pre-edge pending),
  // then each channel's timer, overrun and pending update.
  task automatic modelStep();
    int      clr;
    int      cap;
    int      c;
    bit      fire;
    packet_t p;
    clr = -1;
    if (mStage == 0) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        c = (mLast + off) % NUM_CH;
        if (mStage == 0 && mPend[c]) begin
          mSel   = c;
          mStage = 1;
        end
      end
    end else if (mStage == 1) begin
      clr    = mSel;
      p.ch   = mSel;
      p.idx  = mIdx[mSel];
      p.data = storeWord(mSel, mIdx[mSel]);
      expQ.push_back(p);
      mIdx[mSel] = (mIdx[mSel] + 1) % IDX_MOD;
      mLast      = mSel;
      mStage     = 2;
    end else if (outReady) begin
      mStage = 0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      cap  = int'(timerCap[k*TIMER_W +: TIMER_W]);
      fire = (run == 1'b1) && (cap != 0) && (mTimer[k] == cap);
      if (fire && mPend[k] && clr != k) begin
        mOvrFlag[k] = 1'b1;
        if (mOvrCount < OVR_MAX) mOvrCount++;
      end
      if (fire) mPend[k] = 1'b1;
      else if (clr == k) mPend[k] = 1'b0;
      if (cap == 0 || fire) mTimer[k] = 0;
      else if (run == 1'b1) mTimer[k] = (mTimer[k] + 1) % TMR_MOD;
    end
  endtask

  // Model advances on the same edges as the DUT, and resets asynchronously with it.
  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) modelReset();
    else modelStep();
  end

  // Monitor: away from the active edge, compare live outputs with the model
  // and retire a scoreboard entry whenever a packet is handed over.
  initial forever begin
    @(negedge clock);
    cycNum++;
    if (resetn) begin
      checkOutput("out_valid", outValid, (mStage == 2));
      checkOutput("pending", pendingVec, modelPendVec());
      checkOutput("overrun_flags", overrunFlags, modelFlagVec());
      checkOutput("overrun_count", overrunCount, mOvrCount);
      if (!outValid) begin
        checkOutput("out_data_idle", outData, 0);
      end else if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_packet actual ch=%0d idx=%0d required=no packet", outCh, outIdx);
      end else begin
        checkOutput("out_ch", outCh, expQ[0].ch);
        checkOutput("out_idx", outIdx, expQ[0].idx);
        checkOutput("out_data", outData, expQ[0].data);
        if (outReady) begin
          void'(expQ.pop_front());
          chLog.push_back(int'(outCh));
          idxLog.push_back(int'(outIdx));
          cycLog.push_back(cycNum);
          acceptCount++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic setCap(input int ch, input int val);
    timerCap[ch*TIMER_W +: TIMER_W] = TIMER_W'(val);
  endtask

  task automatic applyStimulus(input logic runV, input logic readyV);
    run      = runV;
    outReady = readyV;
  endtask

  task automatic clearLogs();
    chLog.delete();
    idxLog.delete();
    cycLog.delete();
    acceptCount = 0;
  endtask

  task automatic resetDut();
    resetn   = 1'b0;
    timerCap = '0;
    applyStimulus(1'b0, 1'b1);
    tick(3);
    clearLogs();
    resetn = 1'b1;
  endtask

  task automatic waitAccepted(input int target, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (acceptCount < target && cyc < budget) begin
      tick(1);
      cyc++;
    end
    checkOutput(name, (acceptCount >= target), 1'b1);
  endtask

  initial begin
    int base;
    int cyc;

    $display("[TB] starting sensor_stream_sim bench");
    tick(2);

    // Single channel, period 10, no backpressure.
    resetDut();
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_data", outData, 0);
    checkOutput("reset_pending", pendingVec, 0);
    setCap(0, 9);
    applyStimulus(1'b1, 1'b1);
    waitAccepted(6, 100, "t1_packets");
    for (int i = 0; i < 6 && i < chLog.size(); i++) begin
      checkOutput("t1_ch", chLog[i], 0);
      checkOutput("t1_idx", idxLog[i], i);
      if (i > 0) checkOutput("t1_period", cycLog[i] - cycLog[i-1], 10);
    end

    // All channels fire together: served in channel order, twice.
    resetDut();
    for (int k = 0; k < NUM_CH; k++) setCap(k, 99);
    applyStimulus(1'b1, 1'b1);
    waitAccepted(8, 200, "t2_first_round");
    waitAccepted(16, 250, "t2_second_round");
    for (int i = 0; i < 16 && i < chLog.size(); i++) begin
      checkOutput("t2_order", chLog[i], i % NUM_CH);
    end
    checkOutput("t2_no_overrun", overrunCount, 0);

    // Backpressure while channel 3 keeps firing.
    resetDut();
    setCap(3, 4);
    applyStimulus(1'b1, 1'b0);
    tick(30);
    checkOutput("t3_held_valid", outValid, 1);
    checkOutput("t3_none_accepted", acceptCount, 0);
    checkOutput("t3_flags", overrunFlags, 8'h08);
    applyStimulus(1'b1, 1'b1);
    waitAccepted(2, 40, "t3_release");
    if (idxLog.size() >= 2) begin
      checkOutput("t3_idx_first", idxLog[0], 0);
      checkOutput("t3_idx_next", idxLog[1], 1);
    end

    // Index wrap on a fast channel.
    resetDut();
    setCap(0, 1);
    applyStimulus(1'b1, 1'b1);
    waitAccepted(65, 400, "t4_packets");
    if (idxLog.size() >= 65) begin
      checkOutput("t4_idx_top", idxLog[63], 63);
      checkOutput("t4_idx_wrap", idxLog[64], 0);
    end

    // Asynchronous reset while a packet is on offer and more is pending.
    resetDut();
    setCap(0, 3);
    applyStimulus(1'b1, 1'b0);
    cyc = 0;
    while (!(outValid && pendingVec[0] && overrunCount != 0) && cyc < 60) begin
      tick(1);
      cyc++;
    end
    checkOutput("t5_setup", (outValid && pendingVec[0] && overrunCount != 0), 1);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("t5_valid", outValid, 0);
    checkOutput("t5_data", outData, 0);
    checkOutput("t5_pending", pendingVec, 0);
    checkOutput("t5_count", overrunCount, 0);
    checkOutput("t5_flags", overrunFlags, 0);
    tick(2);
    setCap(2, 3);
    applyStimulus(1'b1, 1'b1);
    clearLogs();
    resetn = 1'b1;
    waitAccepted(2, 40, "t5_after_reset");
    if (chLog.size() >= 2) begin
      checkOutput("t5_first_ch", chLog[0], 0);
      checkOutput("t5_first_idx", idxLog[0], 0);
      checkOutput("t5_second_ch", chLog[1], 2);
    end

    // run=0 with a packet in flight.
    resetDut();
    setCap(1, 30);
    applyStimulus(1'b1, 1'b1);
    cyc = 0;
    while (!outValid && cyc < 60) begin
      tick(1);
      cyc++;
    end
    applyStimulus(1'b0, 1'b0);
    base = acceptCount;
    tick(5);
    applyStimulus(1'b0, 1'b1);
    tick(45);
    checkOutput("t6_inflight_done", acceptCount - base, 1);
    checkOutput("t6_no_pending", pendingVec, 0);
    applyStimulus(1'b1, 1'b1);
    waitAccepted(base + 2, 60, "t6_resume");

    // Randomized caps, run and ready against the model.
    resetDut();
    for (int blk = 0; blk < 30; blk++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        setCap(k, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)));
      end
      for (int c = 0; c < 50; c++) begin
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
        tick(1);
      end
    end

    // Switch everything off and let remaining pending samples drain.
    timerCap = '0;
    applyStimulus(1'b1, 1'b1);
    tick(40);
    checkOutput("drain_queue", expQ.size(), 0);
    checkOutput("drain_idle", outValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
